// File: rtl/sevenseg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan_mux
// Purpose  : Time-multiplexes DIGITS packed BCD digits onto one shared 4-bit
//            bus that feeds a seven-segment decoder. Each digit slot starts
//            with a short all-off blank interval, then shows one digit.
//            Optional leading-zero blanking drives the decoder blank code
//            4'b1111.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            en               - scan enable (0 = dark, scanner parked)
//            digits_in        - packed BCD, [3:0] = digit 0 (LSD)
//            dp_in            - decimal point request per digit
//            blank_lz         - leading-zero blanking enable
//            bcd              - digit code to decoder (4'b1111 = blank)
//            digit_sel(_n)    - one-hot digit enable and its inverse
//            dp               - decimal point of the selected digit
//            frame_done       - pulse on the last cycle of each frame
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan_mux #(
    parameter int DIGITS       = 4,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [DIGITS-1:0]     digit_sel_n,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_slot_last  = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(DIGITS - 1);
    localparam logic [3:0]       c_blank_code = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    // Slot counter runs 0..TICK_DIV-1 across the whole slot (blank + show).
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Frame snapshot: inputs are frozen for a whole frame to avoid tearing.
    logic [4*DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                snap_lz_q, snap_lz_d;

    logic [3:0]          bcd_q, bcd_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [DIGITS-1:0]   sel_n_q, sel_n_d;
    logic                dp_q, dp_d;
    logic                frame_done_q, frame_done_d;

    logic [DIGITS-1:0]   lz_blank;
    logic                zero_run;

    // ------------------------------------------------------------------
    // Next-state: sequencing of slots, digit index and frame snapshot
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_lz_d     = snap_lz_q;

        if (!en) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d       = S_BLANK;
                    idx_d         = '0;
                    cnt_d         = '0;
                    snap_digits_d = digits_in;
                    snap_dp_d     = dp_in;
                    snap_lz_d     = blank_lz;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == c_blank_last) begin
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == c_slot_last) begin
                        cnt_d   = '0;
                        state_d = S_BLANK;
                        if (idx_q == c_idx_last) begin
                            // Frame boundary: wrap and take a fresh snapshot.
                            idx_d         = '0;
                            snap_digits_d = digits_in;
                            snap_dp_d     = dp_in;
                            snap_lz_d     = blank_lz;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the *next* state so the registered outputs line
    // up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        // A digit is leading-zero blanked when it and every higher digit
        // are zero; digit 0 always shows.
        zero_run = 1'b1;
        lz_blank = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run    = zero_run & (snap_digits_d[4*k +: 4] == 4'd0);
            lz_blank[k] = snap_lz_d & zero_run & (k != 0);
        end

        bcd_d        = c_blank_code;
        sel_d        = '0;
        dp_d         = 1'b0;
        frame_done_d = 1'b0;

        if (state_d == S_SHOW) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (idx_d == IDX_W'(k)) begin
                    sel_d[k] = 1'b1;
                    bcd_d    = lz_blank[k] ? c_blank_code : snap_digits_d[4*k +: 4];
                    dp_d     = snap_dp_d[k];
                end
            end
            frame_done_d = (cnt_d == c_slot_last) && (idx_d == c_idx_last);
        end

        sel_n_d = ~sel_d;
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_lz_q     <= 1'b0;
            bcd_q         <= c_blank_code;
            sel_q         <= '0;
            sel_n_q       <= '1;
            dp_q          <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_lz_q     <= snap_lz_d;
            bcd_q         <= bcd_d;
            sel_q         <= sel_d;
            sel_n_q       <= sel_n_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bcd         = bcd_q;
    assign digit_sel   = sel_q;
    assign digit_sel_n = sel_n_q;
    assign dp          = dp_q;
    assign frame_done  = frame_done_q;

endmodule
`default_nettype wire
